half_byte_frontend: RTL and testbench
=====================================

// Module: half_byte_frontend
// PURPOSE
//  Byte-serial command front end for the half-precision (FP16) coprocessor core.
//  Receives 5-byte frames on the 8-bit input port: sync/opcode byte, then operand A, then operand B.
//  Issues one operation to the FP16 core through a valid/ready handshake.
//  Returns the result as 3 bytes (RES_HI, RES_LO, STATUS) with a per-byte valid strobe.
//  Sits between the pad-level ui_in/uio_in pins and the FP16 arithmetic core.
// PARAMETERS
//  SYNC_NIB   4'hA   required value of cmd[7:4]; frames with any other value are discarded
//  TIMEOUT    64     max cycles in WAIT for res_valid before reporting a timeout (1..255)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  ena        in   1   design enable; low = synchronous abort to IDLE
//  din        in   8   input byte, sampled only when din_stb=1
//  din_stb    in   1   single-cycle byte strobe, already synchronised to clk
//  dout       out  8   output byte, valid only when dout_vld=1
//  dout_vld   out  1   one-cycle strobe per output byte
//  busy       out  1   high in every state except IDLE
//  op_a       out  16  operand A to core (FP16 bits)
//  op_b       out  16  operand B to core
//  op_code    out  3   operation select = cmd[2:0]
//  op_valid   out  1   request valid to core
//  op_ready   in   1   core accepts request
//  res        in   16  core result
//  res_flags  in   5   core exception flags {NV,DZ,OF,UF,NX}
//  res_valid  in   1   one-cycle result strobe from core
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, overrun=0, timeout=0, counter=0.
//  States: IDLE -> GET_AH -> GET_AL -> GET_BH -> GET_BL -> ISSUE -> WAIT -> SEND_H -> SEND_L -> SEND_S -> IDLE.
//  - IDLE: on din_stb with din[7:4]==SYNC_NIB: latch op_code=din[2:0], clear overrun/timeout, go to GET_AH.
//    A bad sync byte is dropped silently and the FSM stays in IDLE. cmd[3] is ignored.
//  - GET_AH/AL/BH/BL: each din_stb loads the next byte (MSB first) into op_a[15:8], op_a[7:0],
//    op_b[15:8], op_b[7:0] and advances one state. There is no inter-byte timeout.
//  - ISSUE: op_valid=1 (registered; asserted the cycle after the BL byte is accepted).
//    Hold op_a/op_b/op_code stable.
//    On a cycle with op_valid & op_ready: next cycle op_valid=0, counter=0, go to WAIT.
//  - WAIT: counter increments each cycle.
//    On res_valid: capture res and res_flags, go to SEND_H. res_valid wins if it coincides with the limit.
//    Otherwise, when counter reaches TIMEOUT-1: set timeout=1, captured result=16'h7E00 (qNaN),
//    flags=0, go to SEND_H.
//  - A res_valid that arrives in ISSUE, or while op_valid is high, is ignored.
//  - SEND_H/SEND_L/SEND_S: one byte per cycle with dout_vld=1 in each cycle.
//    Bytes: res[15:8], then res[7:0], then STATUS = {overrun, timeout, 1'b0, flags[4:0]}.
//    The first output byte appears 1 cycle after the res_valid cycle; 3 consecutive cycles in total.
//  - dout holds its last value when dout_vld=0; dout_vld is never high in two different frames back-to-back.
//  - Overrun: a din_stb in ISSUE, WAIT or SEND_* sets overrun=1. That byte is discarded.
//    The first din_stb after returning to IDLE starts a new frame normally.
//  - ena=0 in any state: next cycle state=IDLE, op_valid=0, dout_vld=0, and the frame is lost.
//    Registered operand values are left unchanged.
//  - Async reset mid-frame: immediate return to reset values. No partial output byte is emitted.
//  - busy is a combinational decode of the state register (state != IDLE).
// TESTING
//  1) Frame A0,3C,00,40,00; op_ready=1; core res=4200, flags=0 after 3 cycles
//     -> op_a=3C00, op_b=4000, op_code=0; dout 42,00,00 on 3 consecutive dout_vld cycles.
//  2) Bad sync byte 50, then frame A1,... -> no op_valid for the 50 byte; frame A1 processed, op_code=1.
//  3) op_ready held low 10 cycles -> op_valid stays high with stable operands for 10 cycles, then one handshake.
//  4) res_valid never returned, TIMEOUT=64 -> after 64 WAIT cycles dout 7E,00,40.
//  5) Extra din_stb during WAIT, core flags=5'b00001 -> STATUS byte 81; next frame's STATUS has overrun cleared.
//  6) ena dropped in GET_BH, then raised -> busy=0 next cycle; no op_valid; a fresh full frame completes normally.

Source files
------------

// File: rtl/half_byte_frontend.sv
// half_byte_frontend
//   Byte-serial command front end for the FP16 coprocessor core.
//   A frame is five bytes on din: a sync/opcode byte (upper nibble must equal
//   SYNC_NIB, low three bits select the operation), then operand A high/low,
//   then operand B high/low. The operation is issued to the core over a
//   valid/ready request, the result is awaited (with a timeout), and three
//   bytes are returned on dout: RES_HI, RES_LO, STATUS.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             design enable; low aborts the frame back to IDLE
//   din, din_stb    input byte and its single-cycle strobe
//   dout, dout_vld  output byte and its single-cycle strobe
//   busy            high whenever the FSM is not in IDLE
//   op_a, op_b      FP16 operands to the core
//   op_code         operation select to the core
//   op_valid        request valid to the core
//   op_ready        core accepts the request
//   res, res_flags  core result and exception flags {NV,DZ,OF,UF,NX}
//   res_valid       single-cycle result strobe from the core
//
// Request handshake: op_valid rises the cycle after the last operand byte is
// accepted and stays high, with op_a/op_b/op_code frozen, until a clock edge
// sees op_valid & op_ready; it drops on the following cycle. Results are only
// listened for in WAIT, so a res_valid seen earlier is ignored.
//
// STATUS byte = {overrun, timeout, 1'b0, flags[4:0]}.

module half_byte_frontend #(
  parameter logic [3:0] SYNC_NIB = 4'hA,
  parameter int         TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  din,
  input  logic        din_stb,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        busy,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [2:0]  op_code,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic [15:0] res,
  input  logic [4:0]  res_flags,
  input  logic        res_valid
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_AH,
    S_GET_AL,
    S_GET_BH,
    S_GET_BL,
    S_ISSUE,
    S_WAIT,
    S_SEND_H,
    S_SEND_L,
    S_SEND_S
  } state_t;

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] res_q, res_q_nxt;
  logic [4:0]  flags_q, flags_nxt;
  logic        overrun, overrun_nxt;
  logic        timeout, timeout_nxt;
  logic [15:0] op_a_nxt, op_b_nxt;
  logic [2:0]  op_code_nxt;
  logic        op_valid_nxt;
  logic [7:0]  dout_nxt;
  logic        dout_vld_nxt;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      res_q    <= 16'd0;
      flags_q  <= 5'd0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      op_a     <= 16'd0;
      op_b     <= 16'd0;
      op_code  <= 3'd0;
      op_valid <= 1'b0;
      dout     <= 8'd0;
      dout_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      res_q    <= res_q_nxt;
      flags_q  <= flags_nxt;
      overrun  <= overrun_nxt;
      timeout  <= timeout_nxt;
      op_a     <= op_a_nxt;
      op_b     <= op_b_nxt;
      op_code  <= op_code_nxt;
      op_valid <= op_valid_nxt;
      dout     <= dout_nxt;
      dout_vld <= dout_vld_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    res_q_nxt    = res_q;
    flags_nxt    = flags_q;
    overrun_nxt  = overrun;
    timeout_nxt  = timeout;
    op_a_nxt     = op_a;
    op_b_nxt     = op_b;
    op_code_nxt  = op_code;
    op_valid_nxt = op_valid;
    dout_nxt     = dout;
    dout_vld_nxt = 1'b0;

    // A byte arriving while the frame is being executed or returned is
    // dropped and remembered as an overrun.
    if (din_stb && (state == S_ISSUE || state == S_WAIT || state == S_SEND_H ||
                    state == S_SEND_L || state == S_SEND_S)) begin
      overrun_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (din_stb && din[7:4] == SYNC_NIB) begin
          op_code_nxt = din[2:0];
          overrun_nxt = 1'b0;
          timeout_nxt = 1'b0;
          state_nxt   = S_GET_AH;
        end
      end
      S_GET_AH: begin
        if (din_stb) begin
          op_a_nxt[15:8] = din;
          state_nxt      = S_GET_AL;
        end
      end
      S_GET_AL: begin
        if (din_stb) begin
          op_a_nxt[7:0] = din;
          state_nxt     = S_GET_BH;
        end
      end
      S_GET_BH: begin
        if (din_stb) begin
          op_b_nxt[15:8] = din;
          state_nxt      = S_GET_BL;
        end
      end
      S_GET_BL: begin
        if (din_stb) begin
          op_b_nxt[7:0] = din;
          op_valid_nxt  = 1'b1;
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_valid && op_ready) begin
          op_valid_nxt = 1'b0;
          cnt_nxt      = 8'd0;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt + 8'd1;
        // The first output byte is loaded straight from the incoming result
        // so it appears the cycle after res_valid.
        if (res_valid) begin
          res_q_nxt    = res;
          flags_nxt    = res_flags;
          dout_nxt     = res[15:8];
          dout_vld_nxt = 1'b1;
          state_nxt    = S_SEND_H;
        end else if (cnt == CNT_LIMIT) begin
          timeout_nxt  = 1'b1;
          res_q_nxt    = 16'h7E00;
          flags_nxt    = 5'd0;
          dout_nxt     = 8'h7E;
          dout_vld_nxt = 1'b1;
          state_nxt    = S_SEND_H;
        end
      end
      S_SEND_H: begin
        dout_nxt     = res_q[7:0];
        dout_vld_nxt = 1'b1;
        state_nxt    = S_SEND_L;
      end
      S_SEND_L: begin
        // Use the next overrun value so a byte arriving right now still shows.
        dout_nxt     = {overrun_nxt, timeout, 1'b0, flags_q};
        dout_vld_nxt = 1'b1;
        state_nxt    = S_SEND_S;
      end
      S_SEND_S: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Disabling abandons the frame; operand registers keep their values.
    if (!ena) begin
      state_nxt    = S_IDLE;
      op_valid_nxt = 1'b0;
      dout_vld_nxt = 1'b0;
      dout_nxt     = dout;
    end
  end

endmodule

// File: tb/tb_half_byte_frontend.sv
// Testbench for half_byte_frontend: table of directed frames, hand-written
// corner sequences (bad sync, enable abort, async reset) and random frames
// checked against a frame-level reference model and a byte scoreboard.

module tb_half_byte_frontend;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [7:0]  din;
  logic        din_stb;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        busy;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  op_code;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] res;
  logic [4:0]  res_flags;
  logic        res_valid;

  half_byte_frontend #(.SYNC_NIB(4'hA), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .din       (din),
    .din_stb   (din_stb),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .busy      (busy),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_code   (op_code),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .res       (res),
    .res_flags (res_flags),
    .res_valid (res_valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         total;
  int         bad;
  logic [7:0] last_dout;
  logic [7:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_vld) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dout_unexpected: got %h expected no byte at %0t", dout, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dout_byte", {24'd0, dout}, {24'd0, mon_e});
        end
        last_dout = dout;
      end else begin
        chk("dout_hold", {24'd0, dout}, {24'd0, last_dout});
      end
    end
  end

  // Reference model: the three bytes a frame must return.
  function automatic void push_expected(input bit given, input logic [15:0] r,
                                        input logic [4:0] fl, input bit ovr);
    logic [15:0] v;
    logic [4:0]  f;
    v = given ? r : 16'h7E00;
    f = given ? fl : 5'd0;
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
    exp_q.push_back({ovr, ~given, 1'b0, f});
  endfunction

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    din     = b;
    din_stb = 1'b1;
    @(negedge clk);
    din_stb = 1'b0;
  endtask

  // res_dly < 0 means the core never answers.
  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] b,
                           input int rdy_dly, input int res_dly, input logic [15:0] r,
                           input logic [4:0] fl, input bit extra, input int gap);
    logic [7:0] bytes[5];
    int res_at;
    int lat;
    bytes[0] = cmd;
    bytes[1] = a[15:8];
    bytes[2] = a[7:0];
    bytes[3] = b[15:8];
    bytes[4] = b[7:0];
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i]);
      if (i < 4) repeat (gap) @(negedge clk);
    end
    chk("op_valid_rise", {31'd0, op_valid}, 32'd1);
    chk("op_a", {16'd0, op_a}, {16'd0, a});
    chk("op_b", {16'd0, op_b}, {16'd0, b});
    chk("op_code", {29'd0, op_code}, {29'd0, cmd[2:0]});
    for (int i = 0; i < rdy_dly; i++) begin
      // a stray result while the request is pending must be ignored
      res_valid = (i == 0);
      res       = 16'hDEAD;
      res_flags = 5'h1F;
      @(negedge clk);
      res_valid = 1'b0;
      chk("op_valid_hold", {31'd0, op_valid}, 32'd1);
      chk("op_a_hold", {16'd0, op_a}, {16'd0, a});
      chk("op_b_hold", {16'd0, op_b}, {16'd0, b});
    end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    chk("op_valid_drop", {31'd0, op_valid}, 32'd0);
    res_at = res_dly + (extra ? 1 : 0);
    lat    = -1;
    for (int c = 0; c < TIMEOUT + 8; c++) begin
      if (dout_vld) begin
        lat = c;
        break;
      end
      din       = 8'hA5;
      din_stb   = extra && (c == 0);
      res_valid = (res_dly >= 0) && (c == res_at);
      res       = r;
      res_flags = fl;
      @(negedge clk);
    end
    din_stb   = 1'b0;
    res_valid = 1'b0;
    chk("result_latency", lat, (res_dly >= 0) ? res_at + 1 : TIMEOUT);
    repeat (3) @(negedge clk);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
    chk("bytes_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] a;
    logic [15:0] b;
    int          rdy;
    int          resd;
    logic [15:0] r;
    logic [4:0]  fl;
    bit          extra;
    logic [7:0]  e_hi;
    logic [7:0]  e_lo;
    logic [7:0]  e_st;
  } vec_t;

  vec_t tbl[7];

  initial begin
    total     = 0;
    bad       = 0;
    last_dout = 8'd0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    din       = 8'd0;
    din_stb   = 1'b0;
    op_ready  = 1'b0;
    res       = 16'd0;
    res_flags = 5'd0;
    res_valid = 1'b0;

    tbl[0] = '{8'hA0, 16'h3C00, 16'h4000, 0, 2, 16'h4200, 5'h00, 1'b0, 8'h42, 8'h00, 8'h00};
    tbl[1] = '{8'hA1, 16'h1111, 16'h2222, 0, 0, 16'hABCD, 5'h10, 1'b0, 8'hAB, 8'hCD, 8'h10};
    tbl[2] = '{8'hA3, 16'h5555, 16'h6666, 10, 1, 16'h0F0F, 5'h02, 1'b0, 8'h0F, 8'h0F, 8'h02};
    tbl[3] = '{8'hA2, 16'h0001, 16'h0002, 0, -1, 16'h1234, 5'h1F, 1'b0, 8'h7E, 8'h00, 8'h40};
    tbl[4] = '{8'hA4, 16'h7BFF, 16'h0400, 1, 3, 16'h1234, 5'h01, 1'b1, 8'h12, 8'h34, 8'h81};
    tbl[5] = '{8'hA5, 16'h8000, 16'h0000, 0, 0, 16'h0000, 5'h1F, 1'b0, 8'h00, 8'h00, 8'h1F};
    tbl[6] = '{8'hAF, 16'hFFFF, 16'h0000, 2, TIMEOUT - 1, 16'hC000, 5'h04, 1'b0, 8'hC0, 8'h00, 8'h04};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_dout_vld", {31'd0, dout_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op_a", {16'd0, op_a}, 32'd0);
    chk("rst_op_b", {16'd0, op_b}, 32'd0);
    chk("rst_op_code", {29'd0, op_code}, 32'd0);
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // bad sync byte is dropped silently
    send_byte(8'h50);
    repeat (3) begin
      chk("badsync_busy", {31'd0, busy}, 32'd0);
      chk("badsync_op_valid", {31'd0, op_valid}, 32'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(tbl[i].e_hi);
      exp_q.push_back(tbl[i].e_lo);
      exp_q.push_back(tbl[i].e_st);
      run_frame(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].rdy, tbl[i].resd,
                tbl[i].r, tbl[i].fl, tbl[i].extra, 0);
    end

    // enable dropped in GET_BH: frame lost, operands kept
    send_byte(8'hA2);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("ena_pre_busy", {31'd0, busy}, 32'd1);
    ena = 1'b0;
    @(negedge clk);
    chk("ena_busy", {31'd0, busy}, 32'd0);
    chk("ena_op_valid", {31'd0, op_valid}, 32'd0);
    ena = 1'b1;
    send_byte(8'h33);
    send_byte(8'h44);
    @(negedge clk);
    chk("ena_after_busy", {31'd0, busy}, 32'd0);
    chk("ena_after_op_valid", {31'd0, op_valid}, 32'd0);
    chk("ena_op_a_kept", {16'd0, op_a}, 32'h1122);
    push_expected(1'b1, 16'h3C00, 5'h00, 1'b0);
    run_frame(8'hA0, 16'h3800, 16'h4400, 0, 2, 16'h3C00, 5'h00, 1'b0, 1);

    // async reset while waiting for the core
    send_byte(8'hA1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    chk("arst_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_op_a", {16'd0, op_a}, 32'd0);
    chk("arst_op_b", {16'd0, op_b}, 32'd0);
    chk("arst_dout_vld", {31'd0, dout_vld}, 32'd0);
    last_dout = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_after_busy", {31'd0, busy}, 32'd0);

    // random frames
    for (int n = 0; n < 25; n++) begin
      logic [7:0]  cmd;
      logic [15:0] a, b, r;
      logic [4:0]  fl;
      int          rdy, resd, gap;
      bit          extra;
      cmd   = {4'hA, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      a     = 16'($urandom);
      b     = 16'($urandom);
      r     = 16'($urandom);
      fl    = 5'($urandom);
      rdy   = $urandom_range(0, 3);
      resd  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 6);
      extra = ($urandom_range(0, 3) == 0);
      gap   = $urandom_range(0, 2);
      push_expected(resd >= 0, r, fl, extra);
      run_frame(cmd, a, b, rdy, resd, r, fl, extra, gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
